// File: rtl/fpu_pkg.sv
// Shared FPU definitions.
//   - Fraction widths for the supported formats.
//   - Operand-control bundle that travels with each adder-stage operand set.
package fpu_pkg;

    localparam int NF_D = 52;  // double
    localparam int NF_S = 23;  // single
    localparam int NF_H = 10;  // half

    // Per-operation control bits presented alongside r/s/t.
    typedef struct packed {
        logic invz;        // negate the aligned addend
        logic killprod;    // addend dominates, drop the product
        logic proddenorm;  // product denormal, keeps the product alive
        logic selsum1;     // pick the +1 compound sum
        logic negsum;      // external negate request
    } op_ctrl_t;

endpackage

// File: rtl/fma_compound_add.sv
// Compound carry-propagate adder for the FMA adder stage.
// Produces sv+cv and sv+cv+1 (both modulo 2^SW) from a carry-save pair.
// Kept separate so a prefix-tree implementation can be dropped in later.
// Ports:
//   sv, cv  in  SW  carry-save sum / carry vectors
//   sum0    out SW  sv + cv
//   sum1    out SW  sv + cv + 1
module fma_compound_add #(
    parameter int SW = 114
) (
    input  logic [SW-1:0] sv,
    input  logic [SW-1:0] cv,
    output logic [SW-1:0] sum0,
    output logic [SW-1:0] sum1
);

    localparam logic [SW-1:0] ONE_SW = {{(SW-1){1'b0}}, 1'b1};

    // Both sums from the same operands; carries out of the MSB are dropped.
    always_comb begin
        sum0 = sv + cv;
        sum1 = sv + cv + ONE_SW;
    end

endmodule

// File: rtl/fma_add_pipe.sv
// Two-stage pipelined FMA product/addend adder with valid/ready flow control.
//   S1: masks the product (killprod), conditionally negates the addend and
//       registers the operands; a 3:2 CSA then reduces them to (sv, cv).
//   S2: compound CPA (+0/+1), selects and conditionally inverts the result;
//       all result outputs are registered.
// Ports:
//   clk, reset_n               clock, async active-low reset
//   in_valid / in_ready        operand handshake
//   flush                      synchronous kill of all in-flight work
//   r, s  [PW]                 partial products
//   t     [SW]                 aligned addend
//   invz, killprod, proddenorm, selsum1, negsum   operand control
//   out_valid / out_ready      result handshake
//   sum [SW], negsum0, negsum1, sumzero            result
module fma_add_pipe
    import fpu_pkg::*;
#(
    parameter int NF      = 52,
    parameter int PW      = 2*(NF+1),
    parameter int SW      = PW+NF,
    parameter bit AUTONEG = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          flush,
    input  logic [PW-1:0] r,
    input  logic [PW-1:0] s,
    input  logic [SW-1:0] t,
    input  logic          invz,
    input  logic          killprod,
    input  logic          proddenorm,
    input  logic          selsum1,
    input  logic          negsum,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [SW-1:0] sum,
    output logic          negsum0,
    output logic          negsum1,
    output logic          sumzero
);

    localparam logic [SW-1:0]    ZERO_SW = {SW{1'b0}};
    localparam logic [SW-1:0]    ONE_SW  = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-PW-1:0] ZEXT    = {(SW-PW){1'b0}};

    // ---------------- handshake ----------------
    logic s1_valid_r, s2_valid_r;
    logic s1_adv_s, s2_adv_s, s1_load_s, s2_load_s;

    // Stage advance terms; in_ready depends only on out_ready and state.
    always_comb begin
        s2_adv_s  = ~s2_valid_r | out_ready;
        s1_adv_s  = ~s1_valid_r | s2_adv_s;
        s1_load_s = s1_adv_s & in_valid & ~flush;
        s2_load_s = s2_adv_s & s1_valid_r & ~flush;
    end

    assign in_ready = s1_adv_s;

    // Valid bits: flush wins over both accept and consume.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else if (flush) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
        end else begin
            if (s1_adv_s) begin
                s1_valid_r <= in_valid;
            end else begin
                s1_valid_r <= s1_valid_r;
            end
            if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
            end else begin
                s2_valid_r <= s2_valid_r;
            end
        end
    end

    // ---------------- stage 1 ----------------
    op_ctrl_t      ctrl_s;
    logic          kill_s;
    logic [SW-1:0] r2_s, s2_s, t2_s;

    // Operand conditioning: proddenorm keeps the product even if killprod is set.
    always_comb begin
        ctrl_s = '{invz: invz, killprod: killprod, proddenorm: proddenorm,
                   selsum1: selsum1, negsum: negsum};
        kill_s = ctrl_s.killprod & ~ctrl_s.proddenorm;
        if (kill_s) begin
            r2_s = ZERO_SW;
            s2_s = ZERO_SW;
        end else begin
            r2_s = {ZEXT, r};
            s2_s = {ZEXT, s};
        end
        if (ctrl_s.invz) begin
            t2_s = ~t + ONE_SW;
        end else begin
            t2_s = t;
        end
    end

    logic [SW-1:0] r2_r, s2_r, t2_r;
    logic          sel_r, neg_r;

    // S1 operand registers, loaded only on accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r2_r  <= ZERO_SW;
            s2_r  <= ZERO_SW;
            t2_r  <= ZERO_SW;
            sel_r <= 1'b0;
            neg_r <= 1'b0;
        end else if (s1_load_s) begin
            r2_r  <= r2_s;
            s2_r  <= s2_s;
            t2_r  <= t2_s;
            sel_r <= ctrl_s.selsum1;
            neg_r <= ctrl_s.negsum;
        end else begin
            r2_r  <= r2_r;
            s2_r  <= s2_r;
            t2_r  <= t2_r;
            sel_r <= sel_r;
            neg_r <= neg_r;
        end
    end

    // ---------------- stage 2 ----------------
    logic [SW-1:0] sv_s, cv_s, maj_s;

    // 3:2 CSA; the carry out of bit SW-1 is discarded (modulo arithmetic).
    always_comb begin
        sv_s  = r2_r ^ s2_r ^ t2_r;
        maj_s = (r2_r & s2_r) | (r2_r & t2_r) | (s2_r & t2_r);
        cv_s  = {maj_s[SW-2:0], 1'b0};
    end

    logic [SW-1:0] sum0_s, sum1_s;

    fma_compound_add #(.SW(SW)) u_cpa (
        .sv   (sv_s),
        .cv   (cv_s),
        .sum0 (sum0_s),
        .sum1 (sum1_s)
    );

    logic [SW-1:0] pick_s, res_s;
    logic          neg_eff_s;

    // Select +0/+1 sum and invert when the effective sign is negative.
    always_comb begin
        if (sel_r) begin
            pick_s = sum1_s;
        end else begin
            pick_s = sum0_s;
        end
        if (AUTONEG) begin
            neg_eff_s = pick_s[SW-1];
        end else begin
            neg_eff_s = neg_r;
        end
        res_s = pick_s ^ {SW{neg_eff_s}};
    end

    logic [SW-1:0] sum_r;
    logic          negsum0_r, negsum1_r, sumzero_r;

    // S2 result registers; they hold while the consumer stalls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r     <= ZERO_SW;
            negsum0_r <= 1'b0;
            negsum1_r <= 1'b0;
            sumzero_r <= 1'b0;
        end else if (s2_load_s) begin
            sum_r     <= res_s;
            negsum0_r <= sum0_s[SW-1];
            negsum1_r <= sum1_s[SW-1];
            sumzero_r <= (res_s == ZERO_SW);
        end else begin
            sum_r     <= sum_r;
            negsum0_r <= negsum0_r;
            negsum1_r <= negsum1_r;
            sumzero_r <= sumzero_r;
        end
    end

    assign out_valid = s2_valid_r;
    assign sum       = sum_r;
    assign negsum0   = negsum0_r;
    assign negsum1   = negsum1_r;
    assign sumzero   = sumzero_r;

endmodule

// File: tb/tb_fma_add_pipe.sv
// Scoreboard bench for fma_add_pipe at NF=4 (PW=10, SW=14).
// Two instances share all inputs: dut_a with AUTONEG=1, dut_b with AUTONEG=0.
module tb_fma_add_pipe;

    localparam int NF = 4;
    localparam int PW = 10;
    localparam int SW = 14;
    localparam int M  = 16384;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic invz = 1'b0, killprod = 1'b0, proddenorm = 1'b0, selsum1 = 1'b0, negsum = 1'b0;
    logic [PW-1:0] r = '0, s = '0;
    logic [SW-1:0] t = '0;

    logic in_ready_a, out_valid_a, negsum0_a, negsum1_a, sumzero_a;
    logic in_ready_b, out_valid_b, negsum0_b, negsum1_b, sumzero_b;
    logic [SW-1:0] sum_a, sum_b;

    fma_add_pipe #(.NF(NF), .AUTONEG(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .flush(flush), .r(r), .s(s), .t(t), .invz(invz), .killprod(killprod),
        .proddenorm(proddenorm), .selsum1(selsum1), .negsum(negsum),
        .out_valid(out_valid_a), .out_ready(out_ready), .sum(sum_a),
        .negsum0(negsum0_a), .negsum1(negsum1_a), .sumzero(sumzero_a));

    fma_add_pipe #(.NF(NF), .AUTONEG(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .flush(flush), .r(r), .s(s), .t(t), .invz(invz), .killprod(killprod),
        .proddenorm(proddenorm), .selsum1(selsum1), .negsum(negsum),
        .out_valid(out_valid_b), .out_ready(out_ready), .sum(sum_b),
        .negsum0(negsum0_b), .negsum1(negsum1_b), .sumzero(sumzero_b));

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    typedef struct {
        int sa;
        int sb;
        bit n0;
        bit n1;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: integer arithmetic modulo 2^SW; inversion as (M-1-x).
    function automatic void model(input int rv, input int sv, input int tv,
                                  input bit iz, input bit kp, input bit pd,
                                  input bit sel, input bit ns,
                                  output int sa, output int sb,
                                  output bit n0, output bit n1);
        int t2, prod, s0, s1, pick;
        bit neg_a;
        t2    = iz ? (M - tv) % M : tv;
        prod  = (kp && !pd) ? 0 : rv + sv;
        s0    = (prod + t2) % M;
        s1    = (s0 + 1) % M;
        n0    = (s0 >= M/2);
        n1    = (s1 >= M/2);
        pick  = sel ? s1 : s0;
        neg_a = sel ? n1 : n0;
        sa    = neg_a ? (M - 1 - pick) : pick;
        sb    = ns ? (M - 1 - pick) : pick;
    endfunction

    // Present one beat; expectation is queued when the DUT accepts it.
    // lit_a/lit_b >= 0 override the model with a hand-derived value.
    task automatic issue(input int rv, input int sv, input int tv,
                         input bit iz, input bit kp, input bit pd,
                         input bit sel, input bit ns,
                         input int lit_a, input int lit_b);
        exp_t e;
        int   n;
        bit   done;
        model(rv, sv, tv, iz, kp, pd, sel, ns, e.sa, e.sb, e.n0, e.n1);
        if (lit_a >= 0) e.sa = lit_a;
        if (lit_b >= 0) e.sb = lit_b;
        @(posedge clk); #2;
        r = rv[PW-1:0]; s = sv[PW-1:0]; t = tv[SW-1:0];
        invz = iz; killprod = kp; proddenorm = pd; selsum1 = sel; negsum = ns;
        in_valid = 1'b1;
        flush = 1'b0;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready_a) begin
                exp_q.push_back(e);
                done = 1'b1;
            end else if (n >= 100) begin
                checks++;
                $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
                done = 1'b1;
            end else begin
                n++;
                @(posedge clk); #2;
            end
        end
    endtask

    task automatic idle();
        @(posedge clk); #2;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    // Call right after issue() into an empty pipe: valid appears after two edges.
    task automatic lat_check(input string name);
        idle();
        @(negedge clk);
        chk({name, "_ov_1cyc"}, out_valid_a, 0);
        @(negedge clk);
        chk({name, "_ov_2cyc"}, out_valid_a, 1);
    endtask

    task automatic drain();
        int n;
        idle();
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: pops and compares on every consumed result.
    initial begin
        bit prev_flush = 1'b0;
        bit prev_stall = 1'b0;
        int h_sum = 0;
        int h_flags = 0;
        exp_t e;
        forever begin
            @(negedge clk); #1;
            if (!reset_n) begin
                prev_flush = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_flush) begin
                    chk("flush_ov_a", out_valid_a, 0);
                    chk("flush_ov_b", out_valid_b, 0);
                end
                if (prev_stall && out_valid_a) begin
                    chk("hold_sum", sum_a, h_sum);
                    chk("hold_flags", {negsum0_a, negsum1_a, sumzero_a}, h_flags);
                end
                if (flush) begin
                    exp_q.delete();
                end else if (out_valid_a && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_out: sum 0x%0h with nothing expected", sum_a);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sum_a", sum_a, e.sa);
                        chk("sum_b", sum_b, e.sb);
                        chk("negsum0", negsum0_a, e.n0);
                        chk("negsum1", negsum1_a, e.n1);
                        chk("negsum0_b", negsum0_b, e.n0);
                        chk("negsum1_b", negsum1_b, e.n1);
                        chk("sumzero_a", sumzero_a, (e.sa == 0) ? 1 : 0);
                        chk("sumzero_b", sumzero_b, (e.sb == 0) ? 1 : 0);
                        chk("out_valid_b", out_valid_b, 1);
                    end
                end
                prev_flush = flush;
                prev_stall = out_valid_a && !out_ready;
                h_sum      = sum_a;
                h_flags    = {negsum0_a, negsum1_a, sumzero_a};
            end
        end
    end

    initial begin
        bit stream_done;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", out_valid_a, 0);
        chk("rst_sum", sum_a, 0);
        chk("rst_flags", {negsum0_a, negsum1_a, sumzero_a}, 0);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready_a, 1);

        // Directed arithmetic
        issue(5, 3, 2, 0, 0, 0, 0, 0, 'h000A, 'h000A);
        lat_check("basic");
        issue(3, 2, 'h10, 1, 0, 0, 0, 0, 'h000A, 'h3FF5);
        issue(3, 2, 'h10, 1, 0, 0, 1, 0, 'h0009, 'h3FF6);
        issue('h3FF, 'h3FF, 'h100, 0, 1, 0, 0, 0, 'h0100, 'h0100);
        issue('h3FF, 'h3FF, 'h100, 0, 1, 1, 0, 0, 'h08FE, 'h08FE);
        issue(0, 0, 0, 1, 0, 0, 0, 0, 'h0000, 'h0000);
        issue(0, 0, 5, 0, 0, 0, 0, 1, 'h0005, 'h3FFA);
        drain();

        // Back-to-back stream with a 3-cycle consumer stall
        fork
            begin
                for (int i = 1; i <= 6; i++) issue(0, 0, i, 0, 0, 0, 0, 0, i, i);
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                @(negedge clk);
                chk("stall_in_ready_a", in_ready_a, 0);
                chk("stall_in_ready_b", in_ready_b, 0);
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // Flush with two beats in flight and a third presented
        issue(0, 0, 'h11, 0, 0, 0, 0, 0, -1, -1);
        issue(0, 0, 'h22, 0, 0, 0, 0, 0, -1, -1);
        @(posedge clk); #2;
        t = 'h33;
        in_valid = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        issue(0, 0, 'h44, 0, 0, 0, 0, 0, 'h0044, 'h0044);
        lat_check("post_flush");
        drain();

        // Asynchronous reset mid-stream
        @(posedge clk); #2;
        out_ready = 1'b0;
        issue(1, 1, 'h7, 0, 0, 0, 0, 0, -1, -1);
        issue(2, 2, 'h9, 0, 0, 0, 0, 0, -1, -1);
        @(posedge clk); #2;
        chk("pre_reset_ov", out_valid_a, 1);
        #1;
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("areset_ov", out_valid_a, 0);
        chk("areset_sum", sum_a, 0);
        chk("areset_flags", {negsum0_a, negsum1_a, sumzero_a}, 0);
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b1;
        issue('h10, 'h20, 'h30, 0, 0, 0, 0, 0, 'h0060, 'h0060);
        lat_check("post_reset");
        drain();

        // Randomised stream with random consumer back-pressure
        stream_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    issue($urandom_range(1023), $urandom_range(1023), $urandom_range(M - 1),
                          1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                          1'($urandom_range(1)), 1'($urandom_range(1)), -1, -1);
                end
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #2;
                    out_ready = ($urandom_range(3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/fma_add_pipe.md
Name: fma_add_pipe

Overview:
- Parametrised, pipelined successor of the FMA product/addend adder stage.
- Zeroes the product when the addend dominates and conditionally negates the aligned addend.
- Forms the +0 and +1 compound sums, then selects and conditionally inverts the result.
- Sits between the multiplier array and the normalisation/LZA stage, with valid/ready flow control so the FPU can stall or flush.

Parameters:
- NF, 52, fraction width (52 double, 23 single, 10 half).
- PW, 2*(NF+1), derived, partial-product width.
- SW, PW+NF, derived, aligned-addend and sum width.
- AUTONEG, 1: 1 = negate from the internal sign of the selected sum; 0 = use the negsum input.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  stage accepts operands
- flush  in  1  synchronous kill of all in-flight work
- r  in  PW  partial product 1
- s  in  PW  partial product 2
- t  in  SW  aligned addend
- invz  in  1  negate addend
- killprod  in  1  addend >> product
- proddenorm  in  1  product denormal; overrides killprod
- selsum1  in  1  select +1 compound sum
- negsum  in  1  external negate request (used only when AUTONEG=0)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  SW  selected, possibly inverted sum
- negsum0  out  1  MSB of +0 sum
- negsum1  out  1  MSB of +1 sum
- sumzero  out  1  sum == 0

Behaviour:
- Reset (async, reset_n=0): both stage valid bits clear. out_valid=0, sum=0, negsum0=0, negsum1=0, sumzero=0. in_ready=1 from the first cycle after deassertion.
- Reset mid-operation discards all in-flight results; no partial output appears.
- Arithmetic is modulo 2^SW, all operands zero-extended.
  - t2 = invz ? (~t + 1) : t
  - kp = killprod & ~proddenorm; r2 = kp ? 0 : r; s2 = kp ? 0 : s
  - sum0 = r2 + s2 + t2; sum1 = sum0 + 1
  - negsum0 = sum0[SW-1]; negsum1 = sum1[SW-1]
  - neg_eff = AUTONEG ? (selsum1 ? negsum1 : negsum0) : negsum
  - sum = (selsum1 ? sum1 : sum0) XOR {SW{neg_eff}}
  - sumzero = (sum == 0)
- Stage 1 (S1), on accept: registers t2, r2, s2 (masked), selsum1 and negsum, and performs a 3:2 CSA to carry-save vectors (sv, cv). Carry out of bit SW-1 is discarded.
- Stage 2 (S2): compound CPA on sv+cv (+0/+1), then select/invert. All outputs are registered.
- Latency is 2 cycles: accept at edge N gives out_valid at edge N+2 when there is no stall. Throughput is 1 per cycle.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Result consumed when out_valid & out_ready.
  - S2 advances when ~s2_valid | out_ready.
  - S1 advances when ~s1_valid | S2 advances.
  - in_ready = S1 advances (combinational from out_ready; no combinational in_valid→in_ready path).
- Stall: while out_valid & ~out_ready, sum, negsum0, negsum1 and sumzero hold stable. With S1 also occupied, in_ready=0.
- Flush:
  - At the next edge both valid bits clear and the same-cycle input is dropped even if in_valid & in_ready.
  - Flush wins over accept and consume.
  - The data registers need not clear, but out_valid=0 the cycle after.
- Simultaneous consume and accept on a full pipe: both stages shift; no bubble and no loss.
- Data registers load only on stage advance; no enable toggling otherwise.

Decomposition:
- Shared package fpu_pkg:
  - width constants NF_D=52, NF_S=23, NF_H=10.
  - typedef for the operand-control bundle (invz, killprod, proddenorm, selsum1, negsum).
- One sub-module, fma_compound_add: parametrised SW, combinational, producing sum0/sum1 from sv/cv. Instantiated in S2 so the CPA can later be swapped for a prefix-tree implementation.

Test Plan (NF=4: PW=10, SW=14, AUTONEG=1 unless noted):
- r=0x005, s=0x003, t=0x0002, invz=0, selsum1=0, single beat, out_ready=1 -> out_valid two cycles later; sum=0x000A, negsum0=0, negsum1=0, sumzero=0.
- r=0x003, s=0x002, t=0x0010, invz=1, selsum1=0 -> sum0=0x3FF5, negsum0=1, sum=0x000A. Same with selsum1=1 -> sum1=0x3FF6, negsum1=1, sum=0x0009. With AUTONEG=0 and negsum=0, selsum1=0 -> sum=0x3FF5.
- r=0x3FF, s=0x3FF, t=0x0100, killprod=1, proddenorm=0 -> sum=0x0100. Same with proddenorm=1 -> sum=0x08FE. r=s=0, t=0, invz=1 -> sum=0x0000, sumzero=1.
- Stream 6 back-to-back beats (t=1..6, r=s=0) with out_ready low for cycles 3-5 -> in_ready drops while both stages are full. Outputs hold stable; all 6 results (0x0001..0x0006) appear in order, none lost or duplicated.
- Flush asserted with 2 beats in flight plus in_valid=1 -> out_valid=0 the next cycle and no flushed result ever appears. A beat accepted the cycle after flush emerges 2 cycles later.
- reset_n pulsed low asynchronously mid-stream -> out_valid falls immediately and all outputs read 0. After release the first new beat has 2-cycle latency.
